// File: rtl/alu_seq_ctrl.sv
// Sequencer that latches one ALU request, drives a registered external ALU, and captures its result.
// Optional ALU_SEQ_DIVZERO_TRAP_EN: divide by zero completes at once with err instead of being issued.
module alu_seq_ctrl #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_c,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam logic [4:0] OP_MUL = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b00100;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic        w_accept, w_legal, w_trap, w_md, w_drive;
  logic [3:0]  w_lat_m1;

  assign w_accept = req_valid && req_ready;
  assign w_legal  = (req_op != 5'b00000) && !req_op[4];
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  assign w_trap   = (req_op == OP_DIV) && (req_b == 32'd0);
`else
  assign w_trap   = 1'b0;
`endif
  assign w_md     = (r_op == OP_MUL) || (r_op == OP_DIV);
  assign w_lat_m1 = w_md ? 4'(MD_LAT - 1) : 4'd0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_legal && !w_trap) ? S_ISSUE : S_WB;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_op  <= req_op;
        r_a   <= req_a;
        r_b   <= req_b;
        r_err <= !w_legal || w_trap;
      end
      if (r_state == S_ISSUE) r_cnt <= w_lat_m1;
      // alu_c is valid on the last WAIT cycle; only mul/div own the high half
      if (r_state == S_WAIT) begin
        if (r_cnt == 4'd0) begin
          lo_out <= alu_c[31:0];
          if (w_md) hi_out <= alu_c[63:32];
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign w_drive   = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign alu_op    = w_drive ? r_op : 5'd0;
  assign alu_a     = w_drive ? r_a  : 32'd0;
  assign alu_b     = w_drive ? r_b  : 32'd0;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_WB);
  assign err       = done && r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: registered ALU model, scoreboard of expected completions, vector table plus corner sequences.
module tb_alu_seq_ctrl;
  localparam int MD_LAT = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_c = '0;
  logic [31:0] hi_out, lo_out;
  logic        done, err, busy;

  alu_seq_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .hi_out(hi_out), .lo_out(lo_out), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU model
  always @(posedge clk) begin
    case (alu_op)
      5'd1:    alu_c <= {32'd0, alu_a + alu_b};
      5'd2:    alu_c <= {32'd0, alu_a - alu_b};
      5'd3:    alu_c <= {32'd0, alu_a} * {32'd0, alu_b};
      5'd4:    alu_c <= (alu_b == 0) ? {alu_a, 32'hFFFF_FFFF} : {alu_a % alu_b, alu_a / alu_b};
      5'd5:    alu_c <= {32'd0, alu_a & alu_b};
      5'd6:    alu_c <= {32'd0, alu_a | alu_b};
      5'd7:    alu_c <= {32'd0, alu_a ^ alu_b};
      default: alu_c <= {alu_b, alu_a};
    endcase
  end

  typedef struct {
    logic        err;
    logic [31:0] hi, lo;
    int          hs, lat;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        err;
    logic [31:0] hi, lo;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  bit   saw_div = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (alu_op == 5'b00100) saw_div = 1;
    chk("err_outside_done", {63'd0, err && !done}, 64'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_err", {63'd0, err}, {63'd0, e.err});
        chk("done_hi", {32'd0, hi_out}, {32'd0, e.hi});
        chk("done_lo", {32'd0, lo_out}, {32'd0, e.lo});
        chk("done_latency", 64'(cyc - e.hs), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic e_err, input logic [31:0] e_hi, input logic [31:0] e_lo,
                      input int e_lat, input bit push, output int hs);
    exp_t e;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    hs = -1;
    for (int k = 0; k < 50; k++) begin
      if (req_ready) begin
        hs = cyc;
        if (push) begin
          e.err = e_err; e.hi = e_hi; e.lo = e_lo; e.hs = hs; e.lat = e_lat;
          sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t vt[11];

  initial begin
    int hs, hs2, c0;
    vt[0]  = '{5'b00001, 32'd5, 32'd7, 1'b0, 32'd0, 32'd12, 3};
    vt[1]  = '{5'b00011, 32'h10000, 32'h10000, 1'b0, 32'd1, 32'd0, 6};
    vt[2]  = '{5'b00010, 32'd10, 32'd3, 1'b0, 32'd1, 32'd7, 3};
    vt[3]  = '{5'b10010, 32'd1, 32'd2, 1'b1, 32'd1, 32'd7, 1};
    vt[4]  = '{5'b00100, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 6};
    vt[5]  = '{5'b00000, 32'd3, 32'd4, 1'b1, 32'd2, 32'd14, 1};
    vt[6]  = '{5'b00111, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'd2, 32'hFF00FF00, 3};
    vt[7]  = '{5'b00011, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd1, 32'hFFFFFFFE, 6};
    vt[8]  = '{5'b00101, 32'hFFFF0000, 32'h12345678, 1'b0, 32'd1, 32'h12340000, 3};
    vt[9]  = '{5'b01111, 32'd9, 32'd3, 1'b0, 32'd1, 32'd9, 3};
    vt[10] = '{5'b11111, 32'd6, 32'd6, 1'b1, 32'd1, 32'd9, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'd0, hi_out}, 64'd0);
    chk("rst_lo", {32'd0, lo_out}, 64'd0);
    chk("rst_alu", {27'd0, alu_op, alu_a}, 64'd0);
    chk("rst_flags", {61'd0, done, err, busy}, 64'd0);
    clr = 1'b1;
    @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);

    // Add: ALU driven in the ISSUE and WAIT cycles, zero in WB
    send(5'b00001, 32'd5, 32'd7, 1'b0, 32'd0, 32'd12, 3, 1'b1, hs);
    req_valid = 1'b0;
    chk("add_c1_alu", {27'd0, alu_op, alu_a}, {27'd0, 5'd1, 32'd5});
    chk("add_c1_b", {32'd0, alu_b}, 64'd7);
    chk("add_c1_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("add_c2_op", {59'd0, alu_op}, 64'd1);
    @(negedge clk);
    chk("add_c3_op", {59'd0, alu_op}, 64'd0);
    chk("add_c3_done", {63'd0, done}, 64'd1);
    drain();

    // Vector table
    for (int i = 0; i < 11; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].err, vt[i].hi, vt[i].lo, vt[i].lat, 1'b1, hs);
      req_valid = 1'b0;
      if (vt[i].op == 5'b10010) begin
        chk("ill_c1_ready", {63'd0, req_ready}, 64'd0);
        chk("ill_c1_done_err", {62'd0, done, err}, 64'd3);
        @(negedge clk);
        chk("ill_c2_ready", {63'd0, req_ready}, 64'd1);
      end
      drain();
    end

    // Divide by zero
    saw_div = 0;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    send(5'b00100, 32'd7, 32'd0, 1'b1, 32'd1, 32'd9, 1, 1'b1, hs);
    req_valid = 1'b0;
    drain();
    chk("div0_no_issue", {63'd0, saw_div}, 64'd0);
`else
    send(5'b00100, 32'd7, 32'd0, 1'b0, 32'd7, 32'hFFFFFFFF, MD_LAT + 2, 1'b1, hs);
    req_valid = 1'b0;
    drain();
    chk("div0_issued", {63'd0, saw_div}, 64'd1);
`endif

    // req_valid held across a mul: next accept is the cycle after WB
    send(5'b00011, 32'd3, 32'd5, 1'b0, 32'd0, 32'd15, 6, 1'b1, hs);
    send(5'b00001, 32'd1, 32'd2, 1'b0, 32'd0, 32'd3, 3, 1'b1, hs2);
    req_valid = 1'b0;
    chk("hold_accept_gap", 64'(hs2 - hs), 64'(MD_LAT + 3));
    drain();

    // Reset in cycle 2 of a div discards it
    send(5'b00100, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 6, 1'b0, hs);
    req_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("mid_rst_busy", {62'd0, busy, done}, 64'd0);
    chk("mid_rst_out", {hi_out, lo_out}, 64'd0);
    chk("mid_rst_alu", {27'd0, alu_op, alu_a}, 64'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (8) @(negedge clk);
    c0 = cyc;
    send(5'b00001, 32'd5, 32'd7, 1'b0, 32'd0, 32'd12, 3, 1'b1, hs);
    req_valid = 1'b0;
    chk("post_rst_accept", 64'(hs - c0), 64'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one clock domain and an asynchronous, active-low reset.
REQ-002 The block SHALL provide parameter MD_LAT, default 4: ALU cycles for mul (00011) and div (00100), legal range 1..15.
REQ-003 The block SHALL provide port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL provide port clr, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL provide port req_valid, input, 1, request present.
REQ-006 The block SHALL provide port req_ready, output, 1, request accepted when high together with req_valid.
REQ-007 The block SHALL provide port req_op, input, 5, ALU opcode; legal values are 00001..01111.
REQ-008 The block SHALL provide ports req_a and req_b, input, 32 each, operands.
REQ-009 The block SHALL provide ports alu_a and alu_b (output, 32 each) and alu_op (output, 5) to drive the registered ALU.
REQ-010 The block SHALL provide port alu_c, input, 64, registered ALU result.
REQ-011 The block SHALL provide ports hi_out and lo_out, output, 32 each, result registers.
REQ-012 The block SHALL provide port done, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL provide port err, output, 1, qualified by done.
REQ-014 The block SHALL provide port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT, WB.
REQ-016 req_ready SHALL be 1 only in IDLE; requests presented in any other state SHALL be ignored.
REQ-017 In IDLE, on req_valid&&req_ready the block SHALL latch req_op, req_a and req_b.
- A legal op SHALL go to ISSUE.
- An illegal op (00000, or 10000..11111) SHALL go directly to WB with err=1.
REQ-018 ISSUE SHALL last 1 cycle and drive the latched alu_op/alu_a/alu_b.
- The 4-bit counter SHALL load lat-1, where lat=MD_LAT for mul/div and lat=1 otherwise.
- The next state SHALL be WAIT.
REQ-019 alu_op/alu_a/alu_b SHALL hold their latched values through ISSUE and WAIT, and SHALL be 0 in IDLE and WB.
REQ-020 WAIT SHALL last exactly lat cycles, decrementing the counter each cycle.
- On the edge leaving WAIT with counter==0, the block SHALL capture alu_c and go to WB.
REQ-021 Capture rules:
- mul/div: hi_out=alu_c[63:32] and lo_out=alu_c[31:0].
- All other ops: lo_out=alu_c[31:0], hi_out unchanged.
REQ-022 WB SHALL last 1 cycle with done=1, then return to IDLE.
- err SHALL be 0 in WB unless set per REQ-017 or REQ-031.
REQ-023 Latency: for a handshake in cycle N, done SHALL be high in cycle N+lat+2.
- Illegal op: done SHALL be high in cycle N+1.
REQ-024 Throughput SHALL be one op per lat+3 cycles, because the earliest next accept is the cycle after WB.
REQ-025 On an error completion, hi_out and lo_out SHALL remain unchanged.
REQ-026 done and err SHALL be 0 outside WB.

Reset
REQ-027 clr low SHALL immediately force:
- state IDLE;
- hi_out, lo_out, alu_a, alu_b, alu_op, counter = 0;
- done, err, busy = 0; req_ready = 1 once clr is released.
REQ-028 A reset during ISSUE or WAIT SHALL discard the in-flight op with no done pulse.
REQ-029 A reset during WB SHALL suppress the remainder of that done pulse.
REQ-030 After clr deasserts, the first rising edge with req_valid=1 SHALL accept a request.

Configuration
REQ-031 With macro ALU_SEQ_DIVZERO_TRAP_EN defined, div with req_b==0 SHALL skip ISSUE/WAIT.
- The block SHALL go directly to WB with err=1.
- hi_out and lo_out SHALL remain unchanged.
- done SHALL be high in cycle N+1.
REQ-032 Without ALU_SEQ_DIVZERO_TRAP_EN, div with req_b==0 SHALL be issued normally with lat=MD_LAT, err=0, and the result taken from alu_c as-is.

Verification
REQ-033 add: A=5, B=7, handshake in cycle 0 -> alu_op=00001 in cycles 1-2; done in cycle 3; lo_out=12; hi_out unchanged; err=0.
REQ-034 mul, MD_LAT=4: A=0x10000, B=0x10000, ALU model returns 0x1_00000000 -> done in cycle 6; hi_out=1, lo_out=0.
REQ-035 req_op=10010 -> done and err in cycle 1; hi_out/lo_out unchanged; req_ready low in cycle 1 only.
REQ-036 req_valid held high during a mul -> the second request is accepted only in the cycle after WB; no request is lost or duplicated.
REQ-037 clr pulsed low in cycle 2 of a div -> no done pulse; outputs zeroed; the next add completes normally.
REQ-038 div, B=0: with ALU_SEQ_DIVZERO_TRAP_EN -> done+err in cycle 1, alu_op never 00100; without it -> done in cycle MD_LAT+2, err=0.
